// File: rtl/hv_run_sched.sv
// Job sequencer for one HPU run: item-memory generation phase, then a j-by-i
// compute loop over the input stream that issues exec/last_j/s_fin pulses.
module hv_run_sched #(
   parameter int ADDR_W = 20,
   parameter int MAT_W  = 16
) (
   input  logic              AXIS_ACLK,
   input  logic              AXIS_ARESETN,
   input  logic              start,
   input  logic              abort,
   input  logic [MAT_W-1:0]  cfg_mat_num,
   input  logic [ADDR_W-1:0] cfg_addr_i,
   input  logic [ADDR_W-1:0] cfg_addr_j,
   input  logic              src_valid,
   input  logic              dst_ready,
   output logic              src_ready,
   output logic              matw,
   output logic [MAT_W-1:0]  mat_a,
   output logic              exec,
   output logic              last_j,
   output logic              update,
   output logic              s_fin,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t             state_q;

   logic [MAT_W-1:0]   mat_num_q;
   logic [ADDR_W-1:0]  addr_i_q;
   logic [ADDR_W-1:0]  addr_j_q;

   logic [MAT_W-1:0]   mat_a_q, mat_a_d;
   logic [ADDR_W-1:0]  i_q, i_d;
   logic [ADDR_W-1:0]  j_q, j_d;

   logic               matw_q;
   logic               busy_q;
   logic               done_q;
   logic               exec_q;
   logic               last_j_q;
   logic               s_fin_q;

   logic               beat_acc;
   logic               row_end;
   logic               job_end;

   // Downstream backpressure is passed straight through while streaming.
   assign src_ready = (state_q == ST_RUN) & dst_ready;
   assign beat_acc  = src_valid & src_ready;
   assign row_end   = (j_q == addr_j_q);
   assign job_end   = row_end & (i_q == addr_i_q);

   always_comb begin
      // NOTE: each next-state value is assigned on every path through this
      // block, so synthesis sees pure combinational logic and infers no latch.
      mat_a_d = mat_a_q + MAT_W'(1);
      j_d     = j_q + ADDR_W'(1);
      i_d     = i_q;
      if (row_end) begin
         j_d = '0;
         i_d = i_q + ADDR_W'(1);
      end
      if (job_end) begin
         i_d = '0;
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge AXIS_ACLK) begin
      if (!AXIS_ARESETN) begin
         state_q   <= ST_IDLE;
         mat_num_q <= '0;
         addr_i_q  <= '0;
         addr_j_q  <= '0;
         mat_a_q   <= '0;
         i_q       <= '0;
         j_q       <= '0;
         matw_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         exec_q    <= 1'b0;
         last_j_q  <= 1'b0;
         s_fin_q   <= 1'b0;
      end else begin
         exec_q   <= 1'b0;
         last_j_q <= 1'b0;
         s_fin_q  <= 1'b0;

         if (abort) begin
            // Cancel: leaves done untouched and drops any beat seen this cycle.
            state_q <= ST_IDLE;
            matw_q  <= 1'b0;
            busy_q  <= 1'b0;
            mat_a_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     state_q   <= ST_GEN;
                     mat_num_q <= cfg_mat_num;
                     addr_i_q  <= cfg_addr_i;
                     addr_j_q  <= cfg_addr_j;
                     mat_a_q   <= '0;
                     i_q       <= '0;
                     j_q       <= '0;
                     matw_q    <= 1'b1;
                     busy_q    <= 1'b1;
                     done_q    <= 1'b0;
                  end
               end

               ST_GEN: begin
                  if (mat_a_q == mat_num_q) begin
                     state_q <= ST_RUN;
                     matw_q  <= 1'b0;
                     mat_a_q <= '0;
                  end else begin
                     mat_a_q <= mat_a_d;
                  end
               end

               ST_RUN: begin
                  if (beat_acc) begin
                     exec_q   <= 1'b1;
                     last_j_q <= row_end;
                     s_fin_q  <= job_end;
                     i_q      <= i_d;
                     j_q      <= j_d;
                     if (job_end) begin
                        state_q <= ST_FIN;
                     end
                  end
               end

               ST_FIN: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end

               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  matw_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign matw   = matw_q;
   assign mat_a  = mat_a_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign exec   = exec_q;
   assign last_j = last_j_q;
   assign update = last_j_q;
   assign s_fin  = s_fin_q;

endmodule
